// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART: buffers characters with their line-status bits,
// reports occupancy, sticky overrun/underrun and an error-anywhere flag for LSR[7].
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            err_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  fifo_clear,
  input  logic                  status_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            err_out,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  error_in_fifo
);

  localparam logic [PTR_WIDTH:0] LP_DEPTH = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH+2:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH:0]    r_count;
  logic [PTR_WIDTH:0]    r_err_cnt;
  logic                  r_overrun;
  logic                  r_underrun;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_set_ovr;
  logic                  w_set_und;
  logic                  w_err_inc;
  logic                  w_err_dec;
  logic [DATA_WIDTH+2:0] w_head;

  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == LP_DEPTH);
    w_head    = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    w_push_ok = push && !fifo_clear && (!w_full || pop);
    w_pop_ok  = pop  && !fifo_clear && !w_empty;
    w_set_ovr = push && !fifo_clear && w_full && !pop;
    w_set_und = pop  && !fifo_clear && w_empty;
    w_err_inc = w_push_ok && (err_in != 3'b000);
    w_err_dec = w_pop_ok  && (w_head[DATA_WIDTH+2:DATA_WIDTH] != 3'b000);
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {err_in, data_in};
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else if (fifo_clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_err_inc, w_err_dec})
        2'b10:   r_err_cnt <= r_err_cnt + 1'b1;
        2'b01:   r_err_cnt <= r_err_cnt - 1'b1;
        default: r_err_cnt <= r_err_cnt;
      endcase
    end
  end

  // Set has priority over status_clr so an event in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_set_ovr)       r_overrun <= 1'b1;
      else if (status_clr) r_overrun <= 1'b0;
      if (w_set_und)       r_underrun <= 1'b1;
      else if (status_clr) r_underrun <= 1'b0;
    end
  end

  always_comb begin
    data_out      = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    err_out       = w_empty ? '0 : w_head[DATA_WIDTH+2:DATA_WIDTH];
    count         = r_count;
    empty         = w_empty;
    full          = w_full;
    overrun       = r_overrun;
    underrun      = r_underrun;
    error_in_fifo = (r_err_cnt != '0);
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side FIFO of the UART core. It sits between the serial receiver and the Wishbone register file, which reads it as RBR. It buffers received characters together with their per-character line-status bits (parity error, framing error, break) and reports occupancy, sticky overrun/underrun, and an "error anywhere in FIFO" flag for LSR bit 7. Unlike the transmit FIFO, every entry carries status bits, and the block tracks how many stored entries are errored.

## Interface
Parameters:
- DATA_WIDTH, 8, character width.
- DEPTH, 16, number of entries; power of two.
- PTR_WIDTH, 4, log2(DEPTH).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- wb_rst_i  in  1  asynchronous reset, active-low.
- data_in  in  DATA_WIDTH  received character from the receiver.
- err_in  in  3  status of that character: bit0 parity error, bit1 framing error, bit2 break.
- push  in  1  write strobe, active high, one entry per cycle.
- pop  in  1  read strobe, active high (RBR read), one entry per cycle.
- fifo_clear  in  1  synchronous flush (FCR bit 1).
- status_clr  in  1  clears the sticky overrun and underrun flags (LSR read).
- data_out  out  DATA_WIDTH  head character, show-ahead.
- err_out  out  3  head character's status bits.
- count  out  PTR_WIDTH+1  number of stored entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky: a push was dropped because the FIFO was full.
- underrun  out  1  sticky: a pop hit an empty FIFO.
- error_in_fifo  out  1  at least one stored entry has a nonzero err field.

## Operation
- Storage: DEPTH × (DATA_WIDTH+3) array, write pointer, read pointer, count register, and errored-entry counter err_cnt (PTR_WIDTH+1 bits). Pointers are PTR_WIDTH bits and wrap modulo DEPTH with no special-casing.
- Push accepted when count < DEPTH, or when count == DEPTH and pop is asserted in the same cycle. On accept: store {err_in, data_in} at the write pointer, then increment the write pointer.
- Push when full without pop: the entry is dropped, storage is unchanged, and overrun is set.
- Pop effective when count > 0. On pop: increment the read pointer.
- Pop when count == 0: no pointer change and underrun is set. This holds even if push is asserted in the same cycle; that push is still accepted.
- Count update: +1 on push only, −1 on pop only, unchanged when both are effective.
- err_cnt: +1 for an accepted push with err_in != 0; −1 for an effective pop whose head err_out != 0; the two net when both occur. error_in_fifo = (err_cnt != 0).
- Outputs data_out and err_out are combinational from the read-pointer entry, forced to 0 when empty.
- fifo_clear has priority over push and pop in its cycle. It zeroes both pointers, count and err_cnt, and the push/pop in that cycle are ignored. It does not touch overrun or underrun.
- status_clr clears overrun and underrun. If a set condition occurs in the same cycle, set wins.
- Reset (asynchronous, mid-operation allowed): pointers, count, err_cnt, overrun and underrun go to 0. Array contents are don't-care.

## Timing
- Reset values: data_out 0, err_out 0, count 0, empty 1, full 0, overrun 0, underrun 0, error_in_fifo 0.
- Push latency is one edge. A push sampled at edge N makes count, empty, full and error_in_fifo reflect it after edge N. If the FIFO was empty, data_out and err_out show the new entry after edge N.
- A pop sampled at edge N presents the next entry on data_out after edge N. The consumer samples data_out before asserting pop.
- Sticky flags are set on the edge that samples the offending strobe.
- There is no combinational path from push or pop to any output. All outputs derive from registers plus the array read.

## Test plan
- Reset, then push 0x41/err 0, 0x42/err 0, 0x43/err 0; pop three times → data_out sequence 0x41, 0x42, 0x43, count 3→0, empty=1, error_in_fifo=0 throughout.
- Push 16 entries 0x00..0x0F, then a 17th 0xFF → full=1, count=16, overrun=1, pops return 0x00..0x0F (0xFF absent). Then status_clr → overrun=0.
- With the FIFO full, push 0xAA and pop in the same cycle → count stays 16, no overrun. After 15 further pops, data_out=0xAA.
- Push 0x10/err 3'b010, 0x11/err 0, 0x12/err 3'b100 → error_in_fifo=1. Pop 0x10 → still 1. Pop 0x11 → still 1. Pop 0x12 → 0.
- Pop on empty with a simultaneous push of 0x55 → underrun=1, count=1, data_out=0x55.
- With 5 entries (2 errored) stored, assert fifo_clear with push high → count=0, empty=1, error_in_fifo=0, pointers reset. Next push 0x77 appears on data_out after one edge. Repeat with wb_rst_i low mid-stream → all outputs at reset values immediately, without waiting for a clock edge.
